// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: bundles the fetch port, the data port and the memory macro
// port of the unified-memory arbiter.
//   master : the arbiter side (drives acks, read data and the mem_* bus)
//   slave  : the pipeline/memory side (drives requests and memory returns)
interface mem_port_arb_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    // Instruction-fetch port (read-only)
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    // Data-memory port (load/store)
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    // Single-port memory macro
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one single-port memory between instruction fetch and
// the data stage. The winning request is registered onto the memory port,
// held through any number of wait states, and completed with a one-cycle
// registered ack. Data wins ties.
//
// Optional feature (macro ARB_STARVE_GUARD_EN): a saturating counter of
// consecutive data wins taken while fetch was waiting; once it reaches
// STARVE_MAX the next contested grant goes to fetch.
module mem_port_arb #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arb_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        ACK     = 2'd3
    } state_e;

    state_e        state_q,     state_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
    logic          if_ack_q,    if_ack_d;
    logic          dm_ack_q,    dm_ack_d;

    logic          force_if_s;
    logic          grant_dm_s;
    logic          grant_if_s;

    // A zero limit would hand every contested grant to fetch; leave this
    // block empty so such a build stands out in the elaborated hierarchy.
    if (STARVE_MAX < 1) begin : g_starve_max_invalid
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q, starve_d;

    // Fetch overrides data priority once data has won STARVE_MAX times in a row.
    always_comb begin
        force_if_s = bus.if_req && bus.dm_req && (starve_q == STARVE_LIMIT);
    end

    // Starve counter: counts data grants made while fetch waits, saturating;
    // cleared by a fetch grant or by fetch not requesting in IDLE.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (grant_if_s || !bus.if_req) begin
                starve_d = {CW{1'b0}};
            end else if (grant_dm_s && (starve_q != STARVE_LIMIT)) begin
                starve_d = starve_q + CW'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= {CW{1'b0}};
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict data priority: fetch never overrides.
    always_comb begin
        force_if_s = 1'b0;
    end
`endif

    // Grant decision for the current IDLE cycle.
    always_comb begin
        grant_dm_s = bus.dm_req && !force_if_s;
        grant_if_s = bus.if_req && !grant_dm_s;
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_dm_s) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                end else if (grant_if_s) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = {DW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ready) begin
                    state_d    = ACK;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = bus.mem_rdata;
                    if_ack_d   = 1'b1;
                end else begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_DM: begin
                if (bus.mem_ready) begin
                    state_d   = ACK;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    dm_ack_d  = 1'b1;
                    // Stores complete without touching the load-data register.
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    state_d = BUSY_DM;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            if_rdata_q  <= {DW{1'b0}};
            dm_rdata_q  <= {DW{1'b0}};
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: randomized requesters and a wait-state memory drive the
// arbiter; a transaction-level reference model predicts every output each
// cycle. Build with +define+ARB_STARVE_GUARD_EN to exercise the starve guard.
module tb_mem_port_arb;

    localparam int unsigned AW         = 16;
    localparam int unsigned DW         = 16;
    localparam int unsigned STARVE_MAX = 2;
    localparam int          N_CYCLES   = 3000;

    logic clk;
    logic rst_n;

    mem_port_arb_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory contents (aliased on the low six address bits)
    logic [DW-1:0] mem_a [0:63];

    // Reference model: who owns the memory, and whether this is the ack cycle
    int            m_owner;     // 0 = nobody, 1 = fetch, 2 = data
    bit            m_in_ack;
    int            m_starve;
    logic          e_mem_req, e_mem_we, e_if_ack, e_dm_ack;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata, e_if_rdata, e_dm_rdata;
    int            n_if_grants, n_dm_grants;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_in_ack = 0; m_starve = 0;
        e_mem_req = 1'b0; e_mem_we = 1'b0; e_if_ack = 1'b0; e_dm_ack = 1'b0;
        e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
    endtask

    // One clock edge of the arbiter's documented behaviour.
    task automatic model_step();
        bit fetch_first;
        e_if_ack = 1'b0;
        e_dm_ack = 1'b0;
        if (m_in_ack) begin
            m_in_ack = 0;
        end else if (m_owner != 0) begin
            if (bus.mem_ready) begin
                if (m_owner == 1) begin
                    e_if_ack   = 1'b1;
                    e_if_rdata = mem_a[e_mem_addr[5:0]];
                end else begin
                    e_dm_ack = 1'b1;
                    if (e_mem_we) mem_a[e_mem_addr[5:0]] = e_mem_wdata;
                    else          e_dm_rdata = mem_a[e_mem_addr[5:0]];
                end
                e_mem_req = 1'b0;
                e_mem_we  = 1'b0;
                m_owner   = 0;
                m_in_ack  = 1;
            end
        end else begin
            fetch_first = 0;
`ifdef ARB_STARVE_GUARD_EN
            fetch_first = (m_starve == STARVE_MAX) && bus.if_req && bus.dm_req;
`endif
            if (bus.dm_req && !fetch_first) begin
                m_owner = 2; n_dm_grants++;
                e_mem_req = 1'b1; e_mem_we = bus.dm_we;
                e_mem_addr = bus.dm_addr; e_mem_wdata = bus.dm_wdata;
                if (!bus.if_req)                 m_starve = 0;
                else if (m_starve < STARVE_MAX)  m_starve++;
            end else if (bus.if_req) begin
                m_owner = 1; n_if_grants++;
                e_mem_req = 1'b1; e_mem_we = 1'b0;
                e_mem_addr = bus.if_addr; e_mem_wdata = '0;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check_val({ph, "_mem_req"},   32'(bus.mem_req),   32'(e_mem_req));
        check_val({ph, "_mem_we"},    32'(bus.mem_we),    32'(e_mem_we));
        check_val({ph, "_mem_addr"},  32'(bus.mem_addr),  32'(e_mem_addr));
        check_val({ph, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(e_mem_wdata));
        check_val({ph, "_if_ack"},    32'(bus.if_ack),    32'(e_if_ack));
        check_val({ph, "_dm_ack"},    32'(bus.dm_ack),    32'(e_dm_ack));
        check_val({ph, "_if_rdata"},  32'(bus.if_rdata),  32'(e_if_rdata));
        check_val({ph, "_dm_rdata"},  32'(bus.dm_rdata),  32'(e_dm_rdata));
    endtask

    initial begin
        int rst_at;
        int p_req;
        int if_before;
        for (int i = 0; i < 64; i++) mem_a[i] = 16'($urandom);
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        n_if_grants = 0; n_dm_grants = 0;
        model_reset();
        #12;
        compare_all("reset");
        rst_at = 400;
        if_before = 0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            // Continuous contention phase: both stages always requesting.
            p_req = (cyc >= 1500 && cyc < 2100) ? 100 : 45;
            if (cyc == 1500) if_before = n_if_grants;
            if (!bus.if_req || e_if_ack) begin
                bus.if_req  = ($urandom_range(99) < p_req);
                bus.if_addr = 16'($urandom);
            end
            if (!bus.dm_req || e_dm_ack) begin
                bus.dm_req   = ($urandom_range(99) < p_req);
                bus.dm_we    = 1'($urandom);
                bus.dm_addr  = 16'($urandom);
                bus.dm_wdata = 16'($urandom);
            end
            bus.mem_ready = ($urandom_range(99) < 55);
            bus.mem_rdata = mem_a[bus.mem_addr[5:0]];

            // Abort a data access part-way through.
            if (cyc >= rst_at && m_owner == 2 && !m_in_ack) begin
                rst_at += 700;
                rst_n = 1'b0;
                #1;
                check_val("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
                check_val("async_rst_dm_ack",  32'(bus.dm_ack),  32'd0);
                model_reset();
                @(posedge clk);
                #1;
                compare_all("in_rst");
                continue;
            end

            @(posedge clk);
            model_step();
            #1;
            compare_all("run");
        end

        if (n_if_grants == 0 || n_dm_grants == 0) begin
            check_val("both_ports_granted", 32'(n_if_grants > 0 && n_dm_grants > 0), 32'd1);
        end
`ifdef ARB_STARVE_GUARD_EN
        check_val("guard_fetch_progress", 32'(n_if_grants > if_before), 32'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
